fsb_cycle_ctrl: RTL and testbench

- Parametrised 68000 front-side-bus cycle controller: the successor to the single-source FSB tracker.
- Samples nAS on FCLK and tracks the bus-cycle phase.
- Terminates each cycle with nDTACK (normal), nVPA (interrupt-acknowledge/autovector) or nBERR (timeout).
- Supports NSRC ready sources, programmable minimum wait states and a watchdog. Sits between the CPU bus pins and the address-decode/ready logic.

---
 rtl/fsb_cycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fsb_cycle_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsb_cycle_ctrl.sv
// 68000 front-side-bus cycle controller: tracks nAS per FCLK edge and ends each
// bus cycle with nDTACK (ready sources), nVPA (autovector) or nBERR (watchdog).
module fsb_cycle_ctrl #(
    parameter int NSRC     = 2,
    parameter int DTACK_WS = 0,
    parameter int VPA_WS   = 2,
    parameter int TIMEOUT  = 255,
    parameter int CW       = $clog2(TIMEOUT + 1)
) (
    input  logic            FCLK,
    input  logic            RST,
    input  logic            nAS,
    input  logic [NSRC-1:0] RDY,
    input  logic [NSRC-1:0] SEL,
    input  logic            IACS,
    output logic            nDTACK,
    output logic            nVPA,
    output logic            nBERR,
    output logic            AINACT,
    output logic            BACT,
    output logic            CACT,
    output logic [CW-1:0]   WCNT
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        ERR
    } state_t;

    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] TO_LAST_C = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          mode_q, mode_d;        // 1: interrupt-acknowledge (VPA) cycle
    logic          ndtack_q, ndtack_d;
    logic          nvpa_q, nvpa_d;
    logic          nberr_q, nberr_d;
    logic          ainact_q;
    logic          bact_q, bact_d;
    logic          cact_q, cact_d;

    logic          rdy;
    logic          dws_ok;
    logic          vws_ok;

    assign rdy = |(RDY & SEL);

    // A zero wait-state minimum is always satisfied; skip the compare entirely.
    if (DTACK_WS == 0) begin : g_dws_zero
        assign dws_ok = 1'b1;
    end else begin : g_dws_cmp
        localparam logic [CW-1:0] DWS_C = CW'(DTACK_WS);
        assign dws_ok = (wcnt_q >= DWS_C);
    end

    if (VPA_WS == 0) begin : g_vws_zero
        assign vws_ok = 1'b1;
    end else begin : g_vws_cmp
        localparam logic [CW-1:0] VWS_C = CW'(VPA_WS);
        assign vws_ok = (wcnt_q >= VWS_C);
    end

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            mode_q   <= 1'b0;
            ndtack_q <= 1'b1;
            nvpa_q   <= 1'b1;
            nberr_q  <= 1'b1;
            ainact_q <= 1'b1;
            bact_q   <= 1'b0;
            cact_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            mode_q   <= mode_d;
            ndtack_q <= ndtack_d;
            nvpa_q   <= nvpa_d;
            nberr_q  <= nberr_d;
            ainact_q <= nAS;
            bact_q   <= bact_d;
            cact_q   <= cact_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        mode_d   = mode_q;
        ndtack_d = ndtack_q;
        nvpa_d   = nvpa_q;
        nberr_d  = nberr_q;
        bact_d   = bact_q;
        cact_d   = cact_q;

        case (state_q)
            IDLE: begin
                if (!nAS) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                    mode_d  = IACS;
                    bact_d  = 1'b1;
                end
            end

            // Abort, then ack, then timeout: an ack landing on the last count wins.
            WAIT: begin
                if (nAS) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    bact_d  = 1'b0;
                end else if (mode_q && vws_ok) begin
                    state_d = ACK;
                    nvpa_d  = 1'b0;
                    cact_d  = 1'b1;
                end else if (!mode_q && dws_ok && rdy) begin
                    state_d  = ACK;
                    ndtack_d = 1'b0;
                    cact_d   = 1'b1;
                end else if (wcnt_q == TO_LAST_C) begin
                    state_d = ERR;
                    nberr_d = 1'b0;
                    cact_d  = 1'b1;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + ONE_C;
                end
            end

            ACK, ERR: begin
                if (nAS) begin
                    state_d  = IDLE;
                    wcnt_d   = '0;
                    ndtack_d = 1'b1;
                    nvpa_d   = 1'b1;
                    nberr_d  = 1'b1;
                    bact_d   = 1'b0;
                    cact_d   = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                wcnt_d   = '0;
                ndtack_d = 1'b1;
                nvpa_d   = 1'b1;
                nberr_d  = 1'b1;
                bact_d   = 1'b0;
                cact_d   = 1'b0;
            end
        endcase
    end

    assign nDTACK = ndtack_q;
    assign nVPA   = nvpa_q;
    assign nBERR  = nberr_q;
    assign AINACT = ainact_q;
    assign BACT   = bact_q;
    assign CACT   = cact_q;
    assign WCNT   = wcnt_q;

endmodule

// File: tb/tb_fsb_cycle_ctrl.sv
// Bench for fsb_cycle_ctrl: a phase-level reference model fills a scoreboard at
// each FCLK rise; scenario tasks add directed checks of the key edges.
module tb_fsb_cycle_ctrl;

    localparam int NSRC     = 2;
    localparam int DTACK_WS = 0;
    localparam int VPA_WS   = 2;
    localparam int TIMEOUT  = 8;
    localparam int CW       = $clog2(TIMEOUT + 1);
    localparam int VW       = 6 + CW;

    logic            FCLK = 1'b0;
    logic            RST;
    logic            nAS;
    logic            IACS;
    logic [NSRC-1:0] RDY;
    logic [NSRC-1:0] SEL;
    logic            nDTACK, nVPA, nBERR, AINACT, BACT, CACT;
    logic [CW-1:0]   WCNT;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    logic [VW-1:0] sbq[$];

    // Reference model: phase 0 idle, 1 waiting, 2 acknowledged, 3 bus error.
    int   m_phase = 0;
    int   m_cnt   = 0;
    bit   m_iack  = 1'b0;
    logic m_ain   = 1'b1;

    fsb_cycle_ctrl #(
        .NSRC    (NSRC),
        .DTACK_WS(DTACK_WS),
        .VPA_WS  (VPA_WS),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .FCLK  (FCLK),
        .RST   (RST),
        .nAS   (nAS),
        .RDY   (RDY),
        .SEL   (SEL),
        .IACS  (IACS),
        .nDTACK(nDTACK),
        .nVPA  (nVPA),
        .nBERR (nBERR),
        .AINACT(AINACT),
        .BACT  (BACT),
        .CACT  (CACT),
        .WCNT  (WCNT)
    );

    initial forever #5 FCLK = ~FCLK;

    task automatic model_step();
        bit r;
        r     = |(RDY & SEL);
        m_ain = nAS;
        case (m_phase)
            0: if (nAS == 1'b0) begin
                m_phase = 1;
                m_cnt   = 0;
                m_iack  = IACS;
            end
            1: begin
                if (nAS == 1'b1) begin
                    m_phase = 0;
                    m_cnt   = 0;
                end else if (m_iack && m_cnt >= VPA_WS) m_phase = 2;
                else if (!m_iack && m_cnt >= DTACK_WS && r) m_phase = 2;
                else if (m_cnt == TIMEOUT - 1) m_phase = 3;
                else m_cnt = m_cnt + 1;
            end
            default: if (nAS == 1'b1) begin
                m_phase = 0;
                m_cnt   = 0;
            end
        endcase
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {!(m_phase == 2 && !m_iack), !(m_phase == 2 && m_iack), !(m_phase == 3),
                m_ain, (m_phase != 0), (m_phase >= 2), CW'(m_cnt)};
    endfunction

    initial forever begin
        @(posedge FCLK or posedge RST);
        if (RST) begin
            m_phase = 0;
            m_cnt   = 0;
            m_iack  = 1'b0;
            m_ain   = 1'b1;
        end else begin
            model_step();
            sbq.push_back(model_vec());
        end
    end

    initial forever begin
        bit            live;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] act_v;
        @(posedge FCLK);
        live = (RST === 1'b0);
        #1;
        edge_cnt++;
        if (live) begin
            act_v = {nDTACK, nVPA, nBERR, AINACT, BACT, CACT, WCNT};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow edge %0d: output %b with no expectation", edge_cnt, act_v);
            end else begin
                exp_v = sbq.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb edge %0d: got %b want %b (nDTACK nVPA nBERR AINACT BACT CACT WCNT)",
                             edge_cnt, act_v, exp_v);
                end
            end
            checks++;
            if ((int'(!nDTACK) + int'(!nVPA) + int'(!nBERR)) > 1) begin
                errors++;
                $display("FAIL strobe_excl edge %0d: got nDTACK=%b nVPA=%b nBERR=%b want at most one low",
                         edge_cnt, nDTACK, nVPA, nBERR);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1, "bench timeout");
    end

    task automatic edge_n();
        @(posedge FCLK);
        #1;
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        nAS  = 1'b1;
        IACS = 1'b0;
        RDY  = '0;
        SEL  = '0;
        #2;
        checks++;
        if ({nDTACK, nVPA, nBERR, AINACT, BACT, CACT, WCNT} !== {6'b111100, CW'(0)}) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", {nDTACK, nVPA, nBERR, AINACT, BACT, CACT, WCNT},
                     {6'b111100, CW'(0)});
        end
        edge_n();
        edge_n();
        RST = 1'b0;
        edge_n();
        checks++;
        if ({nDTACK, nVPA, nBERR, AINACT, BACT, CACT} !== 6'b111100) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 111100", {nDTACK, nVPA, nBERR, AINACT, BACT, CACT});
        end
    endtask

    task automatic test_dtack_basic();
        RDY  = 2'b11;
        SEL  = 2'b01;
        IACS = 1'b0;
        nAS  = 1'b0;
        edge_n();
        checks++;
        if ({BACT, nDTACK, CACT, WCNT} !== {3'b110, CW'(0)}) begin
            errors++;
            $display("FAIL dtack_start: got %b want %b", {BACT, nDTACK, CACT, WCNT}, {3'b110, CW'(0)});
        end
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) begin
                nAS = 1'bx;
                #4;
                nAS = 1'b0;
            end
            edge_n();
            checks++;
            if ({nDTACK, CACT, BACT} !== 3'b011) begin
                errors++;
                $display("FAIL dtack_hold edge %0d: got %b want 011", i, {nDTACK, CACT, BACT});
            end
        end
        nAS = 1'b1;
        edge_n();
        checks++;
        if ({nDTACK, nVPA, nBERR, AINACT, BACT, CACT} !== 6'b111100) begin
            errors++;
            $display("FAIL dtack_release: got %b want 111100", {nDTACK, nVPA, nBERR, AINACT, BACT, CACT});
        end
    endtask

    task automatic test_dtack_wait();
        SEL = 2'b01;
        RDY = 2'b10;
        nAS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_n();
            checks++;
            if ({nDTACK, WCNT} !== {1'b1, CW'(i)}) begin
                errors++;
                $display("FAIL wait_count edge %0d: got %b want %b", i, {nDTACK, WCNT}, {1'b1, CW'(i)});
            end
        end
        RDY = 2'b11;
        edge_n();
        checks++;
        if ({nDTACK, WCNT} !== {1'b0, CW'(2)}) begin
            errors++;
            $display("FAIL wait_ack: got %b want %b", {nDTACK, WCNT}, {1'b0, CW'(2)});
        end
        RDY = 2'b00;
        SEL = 2'b10;
        edge_n();
        checks++;
        if (nDTACK !== 1'b0) begin
            errors++;
            $display("FAIL wait_ack_held: got nDTACK=%b want 0", nDTACK);
        end
        nAS = 1'b1;
        edge_n();
    endtask

    task automatic test_vpa();
        IACS = 1'b1;
        RDY  = 2'b00;
        SEL  = 2'b01;
        nAS  = 1'b0;
        edge_n();
        IACS = 1'b0;
        RDY  = 2'b11;
        for (int i = 1; i <= 2; i++) begin
            edge_n();
            checks++;
            if ({nVPA, nDTACK} !== 2'b11) begin
                errors++;
                $display("FAIL vpa_wait edge %0d: got %b want 11", i, {nVPA, nDTACK});
            end
        end
        edge_n();
        checks++;
        if ({nVPA, nDTACK, CACT} !== 3'b011) begin
            errors++;
            $display("FAIL vpa_ack: got %b want 011", {nVPA, nDTACK, CACT});
        end
        RDY = 2'b00;
        edge_n();
        nAS = 1'b1;
        edge_n();
        checks++;
        if ({nVPA, BACT} !== 2'b10) begin
            errors++;
            $display("FAIL vpa_release: got %b want 10", {nVPA, BACT});
        end
    endtask

    task automatic test_timeout();
        IACS = 1'b0;
        SEL  = 2'b00;
        RDY  = 2'b11;
        nAS  = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            edge_n();
            checks++;
            if ({nBERR, nDTACK} !== 2'b11) begin
                errors++;
                $display("FAIL to_wait edge %0d: got %b want 11", i, {nBERR, nDTACK});
            end
        end
        edge_n();
        checks++;
        if ({nBERR, nDTACK, nVPA, CACT, WCNT} !== {4'b0111, CW'(TIMEOUT - 1)}) begin
            errors++;
            $display("FAIL to_berr: got %b want %b", {nBERR, nDTACK, nVPA, CACT, WCNT},
                     {4'b0111, CW'(TIMEOUT - 1)});
        end
        SEL = 2'b01;
        edge_n();
        nAS = 1'b1;
        edge_n();
        checks++;
        if ({nBERR, CACT, BACT} !== 3'b100) begin
            errors++;
            $display("FAIL to_release: got %b want 100", {nBERR, CACT, BACT});
        end
    endtask

    task automatic test_ack_priority();
        SEL = 2'b01;
        RDY = 2'b00;
        nAS = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) edge_n();
        checks++;
        if (WCNT !== CW'(TIMEOUT - 1)) begin
            errors++;
            $display("FAIL prio_count: got %0d want %0d", WCNT, TIMEOUT - 1);
        end
        RDY = 2'b01;
        edge_n();
        checks++;
        if ({nDTACK, nBERR} !== 2'b01) begin
            errors++;
            $display("FAIL prio_ack: got %b want 01", {nDTACK, nBERR});
        end
        nAS = 1'b1;
        edge_n();
    endtask

    task automatic test_back_to_back();
        SEL = 2'b01;
        RDY = 2'b11;
        nAS = 1'b0;
        edge_n();
        edge_n();
        nAS = 1'b1;
        edge_n();
        checks++;
        if ({BACT, nDTACK} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: got %b want 01", {BACT, nDTACK});
        end
        nAS = 1'b0;
        SEL = 2'b11;
        RDY = 2'b10;
        edge_n();
        checks++;
        if ({BACT, nDTACK, CACT, WCNT} !== {3'b110, CW'(0)}) begin
            errors++;
            $display("FAIL b2b_restart: got %b want %b", {BACT, nDTACK, CACT, WCNT}, {3'b110, CW'(0)});
        end
        edge_n();
        checks++;
        if (nDTACK !== 1'b0) begin
            errors++;
            $display("FAIL b2b_multihot: got nDTACK=%b want 0", nDTACK);
        end
        nAS = 1'b1;
        edge_n();
        SEL = 2'b00;
        nAS = 1'b0;
        edge_n();
        nAS = 1'b1;
        edge_n();
        checks++;
        if ({nDTACK, nVPA, nBERR, BACT, CACT} !== 5'b11100) begin
            errors++;
            $display("FAIL abort: got %b want 11100", {nDTACK, nVPA, nBERR, BACT, CACT});
        end
    endtask

    task automatic test_rst_mid_ack();
        SEL = 2'b01;
        RDY = 2'b11;
        nAS = 1'b0;
        edge_n();
        edge_n();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({nDTACK, BACT, CACT, AINACT, WCNT} !== {4'b1001, CW'(0)}) begin
            errors++;
            $display("FAIL rst_async: got %b want %b", {nDTACK, BACT, CACT, AINACT, WCNT}, {4'b1001, CW'(0)});
        end
        edge_n();
        RST = 1'b0;
        edge_n();
        checks++;
        if ({BACT, nDTACK, WCNT} !== {2'b11, CW'(0)}) begin
            errors++;
            $display("FAIL rst_resume: got %b want %b", {BACT, nDTACK, WCNT}, {2'b11, CW'(0)});
        end
        edge_n();
        checks++;
        if (nDTACK !== 1'b0) begin
            errors++;
            $display("FAIL rst_reack: got nDTACK=%b want 0", nDTACK);
        end
        nAS = 1'b1;
        edge_n();
    endtask

    initial begin
        test_reset();
        test_dtack_basic();
        test_dtack_wait();
        test_vpa();
        test_timeout();
        test_ack_priority();
        test_back_to_back();
        test_rst_mid_ack();
        edge_n();
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
